m_0: RTL and testbench

// - 2-bit level-sensitive D latch with asynchronous reset, instrumented for information-flow

---
 rtl/m_0.sv | 72 +++++++
 tb/tb_m_0.sv | 139 +++++++++++++
 2 files changed

// File: rtl/m_0.sv
// ----------------------------------------------------------------------------
// m_0 : 2-bit level-sensitive D latch with asynchronous active-low reset,
//       instrumented for information-flow tracking (IFT).
//
// Every functional input carries a TAINT_W-bit taint vector. The output taint
// is the OR of the taint of the data source currently driving Q and the
// taints of the controls that select that source.
//
// Ports
//   EN      in   1        latch gate, transparent while high
//   ARST    in   1        asynchronous reset, active low
//   EN_t    in   TAINT_W  taint of EN
//   ARST_t  in   TAINT_W  taint of ARST
//   D       in   WIDTH    data input
//   D_t     in   TAINT_W  taint of D (one label set for the whole vector)
//   Q       out  WIDTH    latched data
//   Q_t     out  TAINT_W  taint of Q
// ----------------------------------------------------------------------------
module m_0 #(
    parameter int WIDTH   = 2,
    parameter int TAINT_W = 32
) (
    input  logic               EN,
    input  logic               ARST,
    input  logic [TAINT_W-1:0] EN_t,
    input  logic [TAINT_W-1:0] ARST_t,
    input  logic [WIDTH-1:0]   D,
    input  logic [TAINT_W-1:0] D_t,
    output logic [WIDTH-1:0]   Q,
    output logic [TAINT_W-1:0] Q_t
);

    // Latched data and the taint captured together with it.
    logic [WIDTH-1:0]   q_q;
    logic [TAINT_W-1:0] st_q;
    logic [WIDTH-1:0]   q_d;
    logic [TAINT_W-1:0] st_d;
    logic [TAINT_W-1:0] q_t_d;

    always_comb begin
        q_d  = D;
        st_d = D_t;
    end

    // Reset has priority over the gate; otherwise the latch is transparent
    // while EN is high and holds the last value when EN falls.
    always_latch begin
        if (!ARST) begin
            q_q  <= '0;
            st_q <= '0;
        end else if (EN) begin
            q_q  <= q_d;
            st_q <= st_d;
        end
    end

    // Output taint is purely combinational. In reset only the reset control
    // selects Q, so only ARST_t propagates. Otherwise the data source is
    // either the live D (transparent) or the stored state (hold), and both
    // control taints propagate because together they select that source.
    always_comb begin
        q_t_d = ARST_t;
        if (ARST) begin
            if (EN) q_t_d = D_t  | EN_t | ARST_t;
            else    q_t_d = st_q | EN_t | ARST_t;
        end
    end

    assign Q   = q_q;
    assign Q_t = q_t_d;

endmodule

// File: tb/tb_m_0.sv
// ----------------------------------------------------------------------------
// tb_m_0 : self-checking bench for the IFT-instrumented D latch m_0.
// The reference keeps an abstract "held value / held taint" pair updated by
// the latch rules and predicts Q and Q_t after every input change.
// ----------------------------------------------------------------------------
module tb_m_0;

    localparam int WIDTH   = 2;
    localparam int TAINT_W = 32;

    logic               EN;
    logic               ARST;
    logic [TAINT_W-1:0] EN_t;
    logic [TAINT_W-1:0] ARST_t;
    logic [WIDTH-1:0]   D;
    logic [TAINT_W-1:0] D_t;
    logic [WIDTH-1:0]   Q;
    logic [TAINT_W-1:0] Q_t;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state: what the latch should currently be storing.
    logic [WIDTH-1:0]   ref_val;
    logic [TAINT_W-1:0] ref_tnt;

    m_0 #(.WIDTH(WIDTH), .TAINT_W(TAINT_W)) dut (
        .EN     (EN),
        .ARST   (ARST),
        .EN_t   (EN_t),
        .ARST_t (ARST_t),
        .D      (D),
        .D_t    (D_t),
        .Q      (Q),
        .Q_t    (Q_t)
    );

    // Apply the latch rules to the reference given the present inputs.
    task automatic ref_update();
        if (ARST === 1'b0) begin
            ref_val = '0;
            ref_tnt = '0;
        end else if (EN === 1'b1) begin
            ref_val = D;
            ref_tnt = D_t;
        end
    endtask

    task automatic check(input string tag);
        logic [WIDTH-1:0]   exp_q;
        logic [TAINT_W-1:0] exp_t;
        exp_q = ref_val;
        if (!ARST)   exp_t = ARST_t;
        else if (EN) exp_t = D_t | EN_t | ARST_t;
        else         exp_t = ref_tnt | EN_t | ARST_t;
        n_checks++;
        assert (Q === exp_q) else begin
            n_fails++;
            $error("FAIL %s Q: got %b expected %b", tag, Q, exp_q);
        end
        n_checks++;
        assert (Q_t === exp_t) else begin
            n_fails++;
            $error("FAIL %s Q_t: got %h expected %h", tag, Q_t, exp_t);
        end
    endtask

    // Controls change first, data 2 ns later, so an EN fall never coincides
    // with a D change: the old D is the one captured on the falling gate.
    task automatic step(input logic arst, input logic en,
                        input logic [WIDTH-1:0] d, input logic [TAINT_W-1:0] dt,
                        input logic [TAINT_W-1:0] ent, input logic [TAINT_W-1:0] arstt,
                        input string tag);
        ARST = arst; EN = en; EN_t = ent; ARST_t = arstt;
        #2;
        ref_update();
        D = d; D_t = dt;
        #3;
        ref_update();
        check(tag);
    endtask

    initial begin
        logic [TAINT_W-1:0] tv [8];
        logic en_r;

        EN = 0; ARST = 1; EN_t = '0; ARST_t = '0; D = '0; D_t = '0;
        ref_val = 'x; ref_tnt = 'x;
        #5;

        // Reset dominates regardless of gate
        step(0, 0, 2'b11, 32'h0, 32'h0, 32'h4, "rst_en0");
        step(0, 1, 2'b11, 32'h0, 32'h0, 32'h4, "rst_en1");

        // Transparent: Q tracks D
        step(1, 1, 2'b01, 32'h1, 32'h0, 32'h0, "transp_01");
        step(1, 1, 2'b10, 32'h1, 32'h0, 32'h0, "transp_10");

        // Hold: gate falls, then data changes
        step(1, 0, 2'b01, 32'h0, 32'h0, 32'h0, "hold_10");

        // Control taint while holding a clean value
        step(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, "ct_rst");
        step(1, 0, 2'b00, 32'h0, 32'h2, 32'h8, "ct_hold_A");
        step(1, 1, 2'b01, 32'h1, 32'h2, 32'h8, "ct_transp_B");

        // Reset pulse mid-transparent, release with EN high
        step(1, 1, 2'b11, 32'h0, 32'h0, 32'h0, "mid_pre");
        step(0, 1, 2'b11, 32'h0, 32'h0, 32'h0, "mid_pulse");
        step(1, 1, 2'b11, 32'h0, 32'h0, 32'h0, "mid_rel_en1");
        // Reset pulse with EN low: stays 0 after release
        step(1, 0, 2'b11, 32'h0, 32'h0, 32'h0, "mid_hold");
        step(0, 0, 2'b11, 32'h0, 32'h0, 32'h0, "mid_pulse_en0");
        step(1, 0, 2'b11, 32'h10, 32'h20, 32'h40, "mid_rel_en0");

        // Sweep: each D value, reset pulse between, gate toggling, taint mixes
        tv[0] = 32'h0;        tv[1] = 32'h1;        tv[2] = 32'h8000_0000;
        tv[3] = 32'hFFFF_FFFF; tv[4] = 32'h0000_FFFF; tv[5] = 32'hA5A5_A5A5;
        tv[6] = 32'h1234_5678; tv[7] = 32'h0F0F_0000;
        for (int dv = 0; dv < 4; dv++) begin
            step(0, 0, WIDTH'(dv), tv[dv], tv[dv+1], tv[dv+2], "sw_rst");
            for (int k = 0; k < 8; k++) begin
                en_r = k[0] ^ 1'b1;
                step(1, en_r, (k[1] ? WIDTH'(dv) : ~WIDTH'(dv)),
                     tv[k], tv[(k+3)%8], tv[(k+5)%8], "sw");
            end
        end

        // Randomised mix of reset, gate, data and taints
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                 WIDTH'($urandom), $urandom, $urandom, $urandom, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
